// File: rtl/adc_reset_sequencer.sv
// adc_reset_sequencer: ordered core-reset and output-enable release after PLL lock.
// Define SYNC_PLL_LOCK_EN to add a two-flop synchronizer on pll_locked_i.
module adc_reset_sequencer #(
  parameter int g_ROC_CYCLES = 100,
  parameter int g_TOC_CYCLES = 16,
  parameter int g_CNT_WIDTH  = 16
) (
  input  logic sys_clk_i,
  input  logic sys_rst_n_i,
  input  logic pll_locked_i,
  input  logic sw_rst_req_i,
  output logic rst_core_n_o,
  output logic oe_en_o,
  output logic rst_done_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD_ROC,
    HOLD_TOC,
    RUN
  } state_t;

  localparam logic [g_CNT_WIDTH-1:0] ROC_LAST =
    g_CNT_WIDTH'(g_ROC_CYCLES - 1);
  localparam logic [g_CNT_WIDTH-1:0] TOC_LAST =
    g_CNT_WIDTH'((g_TOC_CYCLES > 0) ? g_TOC_CYCLES - 1 : 0);
  localparam logic [g_CNT_WIDTH-1:0] CNT_ONE =
    g_CNT_WIDTH'(1);
  localparam logic TOC_SKIP = (g_TOC_CYCLES == 0);

  state_t state_q;
  state_t state_d;
  logic [g_CNT_WIDTH-1:0] cnt_q;
  logic [g_CNT_WIDTH-1:0] cnt_d;
  logic lock;

`ifdef SYNC_PLL_LOCK_EN
  logic [1:0] sync_q;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked_i};
    end
  end

  assign lock = sync_q[1];
`else
  assign lock = pll_locked_i;
`endif

  // Lock loss outranks a software request, which outranks expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock) begin
          state_d = HOLD_ROC;
          cnt_d   = '0;
        end
      end
      HOLD_ROC: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (sw_rst_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == ROC_LAST) begin
          cnt_d   = '0;
          state_d = TOC_SKIP ? RUN : HOLD_TOC;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD_TOC: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (sw_rst_req_i) begin
          state_d = HOLD_ROC;
          cnt_d   = '0;
        end else if (cnt_q == TOC_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (sw_rst_req_i) begin
          state_d = HOLD_ROC;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      rst_core_n_o <= 1'b0;
      oe_en_o      <= 1'b0;
      rst_done_o   <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_core_n_o <= (state_d == HOLD_TOC) || (state_d == RUN);
      oe_en_o      <= (state_d == RUN);
      rst_done_o   <= (state_d == RUN);
      busy_o       <= (state_d == HOLD_ROC) || (state_d == HOLD_TOC);
    end
  end

  a_oe_after_core: assert property (
    @(posedge sys_clk_i) oe_en_o |-> rst_core_n_o
  );

endmodule
